// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding, key count and default hold count.
package key_pkg;

  localparam int unsigned KEY_NUM     = 4;
  localparam int unsigned CNT_MAX_DEF = 999_999;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    PRESSED    = 2'd2,
    REL_FILT   = 2'd3
  } key_fsm_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Single-key debounce channel: 2-flop synchronizer, filter FSM with hold counter, press/release pulses.
// Release pulse generation is enabled by KEY_RELEASE_FLAG_EN; otherwise rel is tied low.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic pressed,
  output logic flag,
  output logic rel,
  output logic press_evt
);

  localparam int unsigned    CW   = cnt_width(CNT_MAX);
  localparam logic [CW-1:0]  CMAX = CW'(CNT_MAX);

  logic          sync1, sync2;
  key_fsm_e      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // Synchronizer idles at 1 so a reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    press_evt = 1'b0;
    case (state)
      IDLE: begin
        if (!sync2) state_nxt = PRESS_FILT;
      end
      PRESS_FILT: begin
        if (sync2) begin
          state_nxt = IDLE;
        end else if (cnt == CMAX) begin
          state_nxt = PRESSED;
          press_evt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (sync2) state_nxt = REL_FILT;
      end
      REL_FILT: begin
        if (!sync2) begin
          state_nxt = PRESSED;
        end else if (cnt == CMAX) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pressed = (state == PRESSED) || (state == REL_FILT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag <= 1'b0;
    else        flag <= press_evt;
  end

`ifdef KEY_RELEASE_FLAG_EN
  logic rel_evt;
  assign rel_evt = (state == REL_FILT) && sync2 && (cnt == CMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel <= 1'b0;
    else        rel <= rel_evt;
  end
`else
  assign rel = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Four-key debouncer top: one key_debounce_ch per key plus per-key LED toggle registers.
// KEY_RELEASE_FLAG_EN enables the key_rel release pulses.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_rel,
  output logic [KEY_NUM-1:0] led_out
);

  logic [KEY_NUM-1:0] press_evt;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX (CNT_MAX)
    ) u_ch (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .key_raw   (key_in[i]),
      .pressed   (key_state[i]),
      .flag      (key_flag[i]),
      .rel       (key_rel[i]),
      .press_evt (press_evt[i])
    );
  end

  // Toggle on the pre-register press event so the LED flips on the same edge key_flag rises.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) led_out <= '0;
    else            led_out <= led_out ^ press_evt;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with CNT_MAX = 9 and a run-length reference model.
module tb_key_debounce;

  localparam int unsigned CMAX      = 9;
  localparam int unsigned HOLD      = CMAX + 2;
  localparam int unsigned FLAG_EDGE = CMAX + 4;
`ifdef KEY_RELEASE_FLAG_EN
  localparam int unsigned REL_EXP = 1;
`else
  localparam int unsigned REL_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_state, key_flag, key_rel, led_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: key_in seen two edges late; a key's debounced level flips
  // after HOLD consecutive reads that disagree with it.
  logic [3:0]  m_d1, m_d2, m_lvl, m_flag, m_rel, m_led;
  int unsigned run [4];

  always #5 clk = ~clk;

  key_debounce #(
    .CNT_MAX (CMAX)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .key_in    (key_in),
    .key_state (key_state),
    .key_flag  (key_flag),
    .key_rel   (key_rel),
    .led_out   (led_out)
  );

  function automatic logic [3:0] exp_rel();
`ifdef KEY_RELEASE_FLAG_EN
    return m_rel;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic model_reset();
    m_d1 = '1; m_d2 = '1; m_lvl = '0; m_flag = '0; m_rel = '0; m_led = '0;
    for (int i = 0; i < 4; i++) run[i] = 0;
  endtask

  task automatic step();
    logic [3:0] rd;
    @(posedge clk);
    if (rst_n) begin
      rd = m_d2; m_d2 = m_d1; m_d1 = key_in;
      m_flag = '0; m_rel = '0;
      for (int i = 0; i < 4; i++) begin
        if (rd[i] == m_lvl[i]) begin
          run[i]++;
          if (run[i] == HOLD) begin
            run[i] = 0;
            m_lvl[i] = ~m_lvl[i];
            if (m_lvl[i]) begin
              m_flag[i] = 1'b1;
              m_led[i]  = ~m_led[i];
            end else begin
              m_rel[i] = 1'b1;
            end
          end
        end else begin
          run[i] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] k);
    @(negedge clk);
    key_in = k;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    key_in = '1;
    rst_n  = 1'b0;
    model_reset();
    #2;
    checks++; if (key_state !== 4'h0) begin errors++; $display("FAIL reset_state got=%h want=0", key_state); end
    checks++; if (key_flag  !== 4'h0) begin errors++; $display("FAIL reset_flag got=%h want=0", key_flag); end
    checks++; if (key_rel   !== 4'h0) begin errors++; $display("FAIL reset_rel got=%h want=0", key_rel); end
    checks++; if (led_out   !== 4'h0) begin errors++; $display("FAIL reset_led got=%h want=0", led_out); end
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    drive(4'b1110);
    for (int e = 1; e <= 30; e++) begin
      step();
      checks++;
      if (key_flag[0] !== (e == FLAG_EDGE)) begin
        errors++; $display("FAIL press_flag_edge%0d got=%b want=%b", e, key_flag[0], (e == FLAG_EDGE));
      end
      checks++;
      if (key_flag !== m_flag) begin errors++; $display("FAIL press_flag_model got=%h want=%h", key_flag, m_flag); end
    end
    checks++; if (key_state[0] !== 1'b1) begin errors++; $display("FAIL press_state got=%b want=1", key_state[0]); end
    checks++; if (led_out[0]   !== 1'b1) begin errors++; $display("FAIL press_led got=%b want=1", led_out[0]); end
  endtask

  task automatic test_bounce();
    logic [3:0]  k;
    int unsigned pulses = 0;
    int          pulse_c = -1;
    for (int c = 0; c < 50; c++) begin
      k = 4'b1110;
      k[1] = (c < 20) ? (((c / 3) % 2) != 0) : 1'b0;
      drive(k);
      step();
      if (key_flag[1] === 1'b1) begin pulses++; pulse_c = c; end
      checks++;
      if (key_flag !== m_flag) begin errors++; $display("FAIL bounce_flag_model c=%0d got=%h want=%h", c, key_flag, m_flag); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL bounce_pulse_count got=%0d want=1", pulses); end
    checks++; if (pulse_c != 30) begin errors++; $display("FAIL bounce_pulse_cycle got=%0d want=30", pulse_c); end
  endtask

  task automatic test_release();
    int unsigned rels = 0;
    drive(4'b1101);
    for (int e = 1; e <= 20; e++) begin
      step();
      if (key_rel[0] === 1'b1) rels++;
      checks++;
      if (key_rel !== exp_rel()) begin errors++; $display("FAIL release_rel_model got=%h want=%h", key_rel, exp_rel()); end
      checks++;
      if (key_flag[0] !== 1'b0) begin errors++; $display("FAIL release_no_flag got=%b want=0", key_flag[0]); end
    end
    checks++; if (rels != REL_EXP) begin errors++; $display("FAIL release_pulses got=%0d want=%0d", rels, REL_EXP); end
    checks++; if (key_state[0] !== 1'b0) begin errors++; $display("FAIL release_state got=%b want=0", key_state[0]); end
    checks++; if (led_out[0]   !== 1'b1) begin errors++; $display("FAIL release_led got=%b want=1", led_out[0]); end
  endtask

  task automatic test_simultaneous();
    drive(4'b1111);
    apply_reset();
    drive(4'b0000);
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if (key_flag !== ((e == FLAG_EDGE) ? 4'hF : 4'h0)) begin
        errors++; $display("FAIL simul_flag_edge%0d got=%h want=%h", e, key_flag, ((e == FLAG_EDGE) ? 4'hF : 4'h0));
      end
    end
    checks++; if (led_out   !== 4'hF) begin errors++; $display("FAIL simul_led got=%h want=f", led_out); end
    checks++; if (key_state !== 4'hF) begin errors++; $display("FAIL simul_state got=%h want=f", key_state); end
  endtask

  task automatic test_reset_midfilter();
    drive(4'b1111);
    apply_reset();
    drive(4'b1011);
    repeat (6) step();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({key_state, key_flag, key_rel, led_out} !== 16'h0) begin
      errors++; $display("FAIL midrst_outputs got=%h want=0", {key_state, key_flag, key_rel, led_out});
    end
    for (int e = 0; e < 3; e++) begin
      step();
      checks++; if (key_flag !== 4'h0) begin errors++; $display("FAIL midrst_flag_in_reset got=%h want=0", key_flag); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if (key_flag !== ((e == FLAG_EDGE) ? 4'b0100 : 4'h0)) begin
        errors++; $display("FAIL midrst_flag_edge%0d got=%h want=%h", e, key_flag, ((e == FLAG_EDGE) ? 4'b0100 : 4'h0));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [3:0]  prev_led;
    int unsigned tog [4];
    int unsigned fcnt [4];
    for (int i = 0; i < 4; i++) begin tog[i] = 0; fcnt[i] = 0; end
    drive(4'b1111);
    apply_reset();
    prev_led = led_out;
    for (int b = 0; b < 1000; b++) begin
      r = $urandom;
      for (int j = 0; j < 10; j++) begin
        drive(r[3:0]);
        step();
        checks++;
        if ({key_state, key_flag, key_rel, led_out} !== {m_lvl, m_flag, exp_rel(), m_led}) begin
          errors++;
          $display("FAIL random_model b=%0d got=%h want=%h", b,
                   {key_state, key_flag, key_rel, led_out}, {m_lvl, m_flag, exp_rel(), m_led});
        end
        checks++;
        if ((key_flag & key_rel) !== 4'h0) begin
          errors++; $display("FAIL random_flag_rel_overlap got=%h want=0", key_flag & key_rel);
        end
        for (int i = 0; i < 4; i++) begin
          if (led_out[i] !== prev_led[i]) tog[i]++;
          if (key_flag[i] === 1'b1) fcnt[i]++;
        end
        prev_led = led_out;
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tog[i] != fcnt[i]) begin errors++; $display("FAIL random_led_toggles key%0d got=%0d want=%0d", i, tog[i], fcnt[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_midfilter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
